// File: rtl/top_spi_nn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | top_spi_nn_pkg : SPI frame layout, register map, reset constants      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package top_spi_nn_pkg;
  localparam int FRAME_BITS = 32;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 24;
  localparam int THRESH_RST = 64;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_INPUT  = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_THRESH = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_WBASE  = 7'h10;

  function automatic logic is_waddr(input logic [ADDR_W-1:0] a, input int nw);
    return (a >= ADDR_WBASE) && (int'(a - ADDR_WBASE) < nw);
  endfunction
endpackage
`default_nettype wire

// File: rtl/top_spi_nn_spi_slave_regif.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_regif : 32-bit SPI slave frame decoder with register port   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module spi_slave_regif
  import top_spi_nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_miso,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_rd_done
);
  localparam logic [5:0] CNT_ADDR_DONE = 6'(ADDR_W);
  localparam logic [5:0] CNT_LAST      = 6'(FRAME_BITS - 1);
  localparam logic [5:0] CNT_FULL      = 6'(FRAME_BITS);

  logic [5:0]        r_cnt;
  logic [DATA_W-2:0] r_shift;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_miso;
  logic              w_active;
  logic              w_last;
  logic [4:0]        w_bit_idx;

  assign w_active  = !i_ss_n && (r_cnt < CNT_FULL);
  assign w_last    = w_active && (r_cnt == CNT_LAST);
  assign w_bit_idx = 5'(CNT_LAST - r_cnt);
  // Only the newest 23 bits are kept: enough for the address at bit 24 and the data at bit 0.
  assign o_rd_addr = {r_shift[ADDR_W-2:0], i_mosi};
  assign o_addr    = r_addr;
  assign o_wr_data = {r_shift, i_mosi};
  assign o_wr_en   = w_last && !r_rw;
  assign o_rd_done = w_last && r_rw;
  assign o_miso    = r_miso & ~i_ss_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_rd_data <= '0;
    end else if (i_ss_n) begin
      r_cnt <= '0;
    end else if (w_active) begin
      r_shift <= {r_shift[DATA_W-3:0], i_mosi};
      r_cnt   <= r_cnt + 6'd1;
      if (r_cnt == '0) r_rw <= i_mosi;
      if (r_cnt == CNT_ADDR_DONE) begin
        r_addr    <= o_rd_addr;
        r_rd_data <= i_rd_data;
      end
    end
  end

  // Read data leaves on the falling edge so the host samples it on the next rising edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_miso <= 1'b0;
    end else if (!i_ss_n && r_rw && (r_cnt > CNT_ADDR_DONE) && (r_cnt <= CNT_LAST)) begin
      r_miso <= r_rd_data[w_bit_idx];
    end else begin
      r_miso <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/top_spi_nn.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | top_spi_nn : LIF spiking network, fully connected, SPI configured     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module top_spi_nn
  import top_spi_nn_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int WEIGHT_W    = 8,
  parameter int POT_W       = 16
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   ss_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic [NUM_NEURONS-1:0] monitor_spikes
);
  localparam int N      = NUM_NEURONS;
  localparam int NW     = N * N;
  localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int WDEPTH = 1 << IDX_W;
  localparam int SUM_W  = ((POT_W > WEIGHT_W) ? POT_W : WEIGHT_W) + 4;
  localparam logic signed [SUM_W-1:0] ZERO = '0;
  localparam logic signed [SUM_W-1:0] ONE  = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] VMAX = {{(SUM_W-POT_W+1){1'b0}}, {(POT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] VMIN = {{(SUM_W-POT_W+1){1'b1}}, {(POT_W-1){1'b0}}};

  logic                    r_run;
  logic [POT_W-1:0]        r_thresh;
  logic [WEIGHT_W-1:0]     r_w [WDEPTH];
  logic signed [POT_W-1:0] r_v [N];
  logic [N-1:0]            r_spk;
  logic [N-1:0]            r_ext;
  logic [N-1:0]            r_status;

  logic [ADDR_W-1:0]       w_rd_addr;
  logic [ADDR_W-1:0]       w_addr;
  logic [DATA_W-1:0]       w_rd_data;
  logic [DATA_W-1:0]       w_wr_data;
  logic                    w_wr_en;
  logic                    w_rd_done;
  logic [IDX_W-1:0]        w_ridx;
  logic [IDX_W-1:0]        w_widx;
  logic [N-1:0]            w_pre;
  logic [N-1:0]            w_fire;
  logic signed [POT_W-1:0] w_v_next [N];
  logic signed [SUM_W-1:0] w_thr;
  logic                    w_unused;

  spi_slave_regif u_spi (
    .clk       (sclk),
    .rst_n     (rst_n),
    .i_ss_n    (ss_n),
    .i_mosi    (mosi),
    .i_rd_data (w_rd_data),
    .o_miso    (miso),
    .o_rd_addr (w_rd_addr),
    .o_addr    (w_addr),
    .o_wr_en   (w_wr_en),
    .o_wr_data (w_wr_data),
    .o_rd_done (w_rd_done)
  );

  assign monitor_spikes = r_spk;
  assign w_ridx   = IDX_W'(w_rd_addr - ADDR_WBASE);
  assign w_widx   = IDX_W'(w_addr - ADDR_WBASE);
  assign w_pre    = r_ext | r_spk;
  assign w_thr    = $signed({{(SUM_W-POT_W){1'b0}}, r_thresh});
  assign w_unused = ^w_wr_data;

  always_comb begin
    w_rd_data = '0;
    case (w_rd_addr)
      ADDR_CTRL:   w_rd_data[0]         = r_run;
      ADDR_STATUS: w_rd_data[N-1:0]     = r_status;
      ADDR_THRESH: w_rd_data[POT_W-1:0] = r_thresh;
      default: if (is_waddr(w_rd_addr, NW)) w_rd_data[WEIGHT_W-1:0] = r_w[w_ridx];
    endcase
  end

  always_comb begin
    logic signed [SUM_W-1:0] acc;
    acc    = ZERO;
    w_fire = '0;
    for (int post = 0; post < N; post++) begin
      acc = SUM_W'(r_v[post]);
      for (int pre = 0; pre < N; pre++) begin
        if (w_pre[pre]) acc = acc + SUM_W'($signed(r_w[IDX_W'(pre*N + post)]));
      end
      if (acc > ZERO)      acc = acc - ONE;
      else if (acc < ZERO) acc = acc + ONE;
      if (acc > VMAX)      acc = VMAX;
      else if (acc < VMIN) acc = VMIN;
      w_fire[post]   = (acc >= w_thr);
      w_v_next[post] = w_fire[post] ? '0 : acc[POT_W-1:0];
    end
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_thresh <= POT_W'(THRESH_RST);
      r_spk    <= '0;
      r_ext    <= '0;
      r_status <= '0;
      for (int i = 0; i < WDEPTH; i++) r_w[i] <= '0;
      for (int i = 0; i < N; i++) r_v[i] <= '0;
    end else begin
      r_ext <= '0;
      if (w_wr_en) begin
        case (w_addr)
          ADDR_CTRL:   r_run    <= w_wr_data[0];
          ADDR_INPUT:  r_ext    <= w_wr_data[N-1:0];
          ADDR_THRESH: r_thresh <= w_wr_data[POT_W-1:0];
          default: if (is_waddr(w_addr, NW)) r_w[w_widx] <= w_wr_data[WEIGHT_W-1:0];
        endcase
      end
      // run=0 holds the core in soft reset; CTRL and the weights survive.
      if (!r_run) begin
        r_spk    <= '0;
        r_status <= '0;
        for (int i = 0; i < N; i++) r_v[i] <= '0;
      end else begin
        r_spk    <= w_fire;
        r_status <= ((w_rd_done && (w_addr == ADDR_STATUS)) ? '0 : r_status) | w_fire;
        for (int i = 0; i < N; i++) r_v[i] <= w_v_next[i];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_top_spi_nn.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_top_spi_nn : scoreboard bench for top_spi_nn (SPI reads, spikes)   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_top_spi_nn;
  import top_spi_nn_pkg::*;
  localparam int N = 4;

  logic         sclk  = 1'b0;
  logic         rst_n = 1'b0;
  logic         ss_n  = 1'b1;
  logic         mosi  = 1'b0;
  logic         miso;
  logic [N-1:0] monitor_spikes;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int           rd_q[$];
  int           sp_cyc_q[$];
  logic [N-1:0] sp_val_q[$];

  top_spi_nn #(.NUM_NEURONS(N), .WEIGHT_W(8), .POT_W(16)) dut (
    .sclk           (sclk),
    .rst_n          (rst_n),
    .ss_n           (ss_n),
    .mosi           (mosi),
    .miso           (miso),
    .monitor_spikes (monitor_spikes)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int vpot(input int i);
    return int'(dut.r_v[i]);
  endfunction

  task automatic frame(input logic [31:0] word, input int nbits, output int ccyc);
    for (int i = 0; i < nbits; i++) begin
      @(negedge sclk); #1;
      ss_n = 1'b0;
      mosi = word[31-i];
    end
    @(negedge sclk); #1;
    ss_n = 1'b1;
    mosi = 1'b0;
    ccyc = cyc;
  endtask

  task automatic wr(input logic [6:0] a, input logic [23:0] d, output int ccyc);
    frame({1'b0, a, d}, 32, ccyc);
  endtask

  task automatic rd(input logic [6:0] a, input int exp);
    int c;
    rd_q.push_back(exp);
    frame({1'b1, a, 24'h0}, 32, c);
  endtask

  // SPI read monitor: reassembles miso bits and scores each completed read frame.
  int          mcnt = 0;
  logic        mrw  = 1'b0;
  logic [23:0] mdata = '0;
  always @(posedge sclk) begin
    if (!rst_n || ss_n) begin
      mcnt = 0;
    end else if (mcnt < 32) begin
      if (mcnt == 0) mrw = mosi;
      if (mcnt >= 8) mdata[31-mcnt] = miso;
      mcnt++;
      if (mcnt == 32 && mrw) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spi_read: got 0x%0h expected no read", mdata);
        end else begin
          check("spi_read", int'(mdata), rd_q.pop_front());
        end
      end
    end
  end

  // Spike monitor: every non-zero spike vector must match the next expected (cycle, vector).
  always @(negedge sclk) begin
    if (rst_n && monitor_spikes != '0) begin
      if (sp_cyc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spike_unexpected: got %b at cycle %0d expected none", monitor_spikes, cyc);
      end else begin
        check("spike_cycle", cyc, sp_cyc_q.pop_front());
        check("spike_vec", int'(monitor_spikes), int'(sp_val_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c2;
    rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    #1;
    check("rst_spikes", int'(monitor_spikes), 0);
    check("rst_miso", int'(miso), 0);
    check("rst_v0", vpot(0), 0);
    rst_n = 1'b1;

    wr(ADDR_CTRL, 24'd0, c);
    wr(ADDR_CTRL, 24'd1, c);
    rd(ADDR_CTRL, 1);

    wr(7'h12, 24'd40, c);
    wr(7'h16, 24'd40, c);
    wr(ADDR_THRESH, 24'd64, c);
    wr(ADDR_INPUT, 24'h3, c);
    sp_cyc_q.push_back(c + 1); sp_val_q.push_back(4'b0100);
    @(negedge sclk); #1;
    check("v2_reset_on_fire", vpot(2), 0);
    rd(ADDR_STATUS, 4);
    rd(ADDR_STATUS, 0);

    rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    #1 rst_n = 1'b1;
    rd(ADDR_THRESH, 64);
    rd(7'h12, 0);
    wr(ADDR_CTRL, 24'd1, c);
    wr(7'h13, 24'd10, c);
    wr(ADDR_INPUT, 24'h1, c);
    for (int k = 1; k <= 12; k++) begin
      @(negedge sclk); #1;
      check("v3_decay", vpot(3), (10 - k > 0) ? 10 - k : 0);
    end

    wr(7'h11, 24'hABCDF0, c);
    rd(7'h11, 'hF0);
    wr(ADDR_INPUT, 24'h1, c);
    for (int k = 1; k <= 20; k++) begin
      @(negedge sclk); #1;
      check("v1_neg_recover", vpot(1), (k < 16) ? k - 16 : 0);
    end

    frame({1'b0, ADDR_CTRL, 24'h0}, 20, c);
    wr(ADDR_THRESH, 24'h50, c);
    rd(ADDR_CTRL, 1);
    rd(ADDR_THRESH, 'h50);
    wr(7'h1F, 24'h5A, c);
    rd(7'h1F, 'h5A);
    wr(7'h20, 24'hFF, c);
    rd(7'h20, 0);
    rd(ADDR_INPUT, 0);
    rd(7'h05, 0);

    wr(7'h13, 24'd0, c);
    wr(7'h10, 24'd100, c);
    wr(ADDR_INPUT, 24'h1, c);
    for (int k = 1; k <= 33; k++) begin
      sp_cyc_q.push_back(c + k); sp_val_q.push_back(4'b0001);
    end
    wr(ADDR_CTRL, 24'd0, c2);
    check("v1_sustained", vpot(1), -495);
    @(negedge sclk); #1;
    check("softrst_spikes", int'(monitor_spikes), 0);
    check("softrst_v1", vpot(1), 0);

    repeat (5) @(negedge sclk);
    #1;
    check("reads_left", rd_q.size(), 0);
    check("spikes_left", sp_cyc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
